// File: rtl/ibex_rf_ctx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ibex_rf_ctx_pkg : state encoding and sizing helper for the ctx engine  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package ibex_rf_ctx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE    = 3'd1,
    RESTORE = 3'd2,
    CSUM    = 3'd3,
    DONE    = 3'd4
  } ctx_state_e;

  function automatic int unsigned num_words(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_rf_ctx_csum.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ibex_rf_ctx_csum : XOR accumulator with clear, enable and compare      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module ibex_rf_ctx_csum #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [DataWidth-1:0] cmp_i,
  output logic [DataWidth-1:0] acc_o,
  output logic                 mismatch_o
);

  logic [DataWidth-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o      = acc_q;
  assign mismatch_o = (cmp_i != acc_q);

endmodule
`default_nettype wire

// File: rtl/ibex_rf_ctx_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ibex_rf_ctx_engine : register-file context save/restore initiator.     |
// | Optional checksum beat: IBEX_RF_CTX_CHECKSUM_EN.  Revision 1.0         |
// +-----------------------------------------------------------------------+
module ibex_rf_ctx_engine
  import ibex_rf_ctx_pkg::*;
#(
  parameter int unsigned RV32E     = 0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [4:0]           rf_raddr_o,
  input  logic [DataWidth-1:0] rf_rdata_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 save_valid_o,
  output logic [DataWidth-1:0] save_data_o,
  input  logic                 save_ready_i,
  input  logic                 rest_valid_i,
  input  logic [DataWidth-1:0] rest_data_i,
  output logic                 rest_ready_o
);

  localparam int unsigned NUM_WORDS = num_words(RV32E != 0);
  localparam logic [4:0]  LAST_IDX  = 5'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE    = 3'(IDLE);
  localparam logic [2:0] S_SAVE    = 3'(SAVE);
  localparam logic [2:0] S_RESTORE = 3'(RESTORE);
  localparam logic [2:0] S_DONE    = 3'(DONE);
`ifdef IBEX_RF_CTX_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'(CSUM);
  localparam logic [2:0] S_LAST    = S_CSUM;
`else
  localparam logic [2:0] S_LAST    = S_DONE;
`endif

  logic [2:0] state_d, state_q;
  logic [4:0] idx_d, idx_q;

`ifdef IBEX_RF_CTX_CHECKSUM_EN
  // dir_q remembers whether the CSUM beat belongs to a save (1) or restore (0)
  logic                 dir_d, dir_q;
  logic                 err_d, err_q;
  logic                 acc_clr, acc_en, acc_mismatch;
  logic [DataWidth-1:0] acc_data, acc_val;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    done_o       = 1'b0;
    rf_raddr_o   = 5'd0;
    rf_waddr_o   = 5'd0;
    rf_wdata_o   = '0;
    rf_we_o      = 1'b0;
    save_valid_o = 1'b0;
    save_data_o  = '0;
    rest_ready_o = 1'b0;
`ifdef IBEX_RF_CTX_CHECKSUM_EN
    dir_d    = dir_q;
    err_d    = err_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    acc_data = rest_data_i;
`endif

    case (state_q)
      S_IDLE: begin
        idx_d = 5'd1;
        if (save_req_i || restore_req_i) begin
          state_d = save_req_i ? S_SAVE : S_RESTORE;
`ifdef IBEX_RF_CTX_CHECKSUM_EN
          dir_d   = save_req_i;
          acc_clr = 1'b1;
          err_d   = 1'b0;
`endif
        end
      end

      S_SAVE: begin
        save_valid_o = 1'b1;
        rf_raddr_o   = idx_q;
        save_data_o  = rf_rdata_i;
        if (save_ready_i) begin
`ifdef IBEX_RF_CTX_CHECKSUM_EN
          acc_en   = 1'b1;
          acc_data = rf_rdata_i;
`endif
          if (idx_q == LAST_IDX) begin
            state_d = S_LAST;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      S_RESTORE: begin
        rest_ready_o = 1'b1;
        if (rest_valid_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = idx_q;
          rf_wdata_o = rest_data_i;
`ifdef IBEX_RF_CTX_CHECKSUM_EN
          acc_en = 1'b1;
`endif
          if (idx_q == LAST_IDX) begin
            state_d = S_LAST;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

`ifdef IBEX_RF_CTX_CHECKSUM_EN
      S_CSUM: begin
        if (dir_q) begin
          save_valid_o = 1'b1;
          save_data_o  = acc_val;
          if (save_ready_i) begin
            state_d = S_DONE;
          end
        end else begin
          rest_ready_o = 1'b1;
          if (rest_valid_i) begin
            state_d = S_DONE;
            if (acc_mismatch) begin
              err_d = 1'b1;
            end
          end
        end
      end
`endif

      S_DONE: begin
        done_o  = 1'b1;
        idx_d   = 5'd1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = 5'd1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);

`ifdef IBEX_RF_CTX_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end

  ibex_rf_ctx_csum #(
    .DataWidth (DataWidth)
  ) u_csum (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (acc_clr),
    .en_i       (acc_en),
    .data_i     (acc_data),
    .cmp_i      (rest_data_i),
    .acc_o      (acc_val),
    .mismatch_o (acc_mismatch)
  );

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire
